uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter IDLE_TIMEOUT, default 1200: clk cycles a locked requester may leave req_valid low before its lock is revoked; 1200 cycles is 100 us at 12 MHz.
REQ-003 clk  in  1  system clock, 12 MHz, all logic on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  NREQ  requester i has a byte on req_data slice i.
REQ-006 req_data  in  8*NREQ  byte for requester i on bits [8i+7:8i].
REQ-007 req_last  in  NREQ  the offered byte is the final byte of the packet.
REQ-008 req_ready  out  NREQ  one-cycle pulse; the offered byte was consumed this cycle.
REQ-009 tx_start  out  1  one-cycle pulse to the shared UART transmitter.
REQ-010 tx_data  out  8  byte to the transmitter; valid while tx_start is high and held afterwards.
REQ-011 tx_busy  in  1  the transmitter is shifting a frame.
REQ-012 grant_valid  out  1  a requester currently holds the transmitter.
REQ-013 grant_id  out  $clog2(NREQ)  index of the holding requester.
REQ-014 timeout_evt  out  1  one-cycle pulse when a lock is revoked by the idle timeout.

Function
REQ-015 All outputs are registered.
REQ-016 The FSM has five states: IDLE, SEND, WAIT_BUSY, WAIT_DONE, RELEASE.
REQ-017 IDLE: if any req_valid is high, the block grants round-robin starting at ptr, sets grant_valid=1 and grant_id, and enters SEND on the next cycle.
REQ-018 SEND, when req_valid[g] is high:
- tx_start=1, tx_data=req_data[g], req_ready[g]=1, all for exactly one cycle;
- req_last[g] is latched into last_q;
- the idle counter clears;
- next state is WAIT_BUSY.
REQ-019 SEND, when req_valid[g] is low: the idle counter increments; when it reaches IDLE_TIMEOUT-1, timeout_evt pulses and the FSM goes to RELEASE.
REQ-020 WAIT_BUSY advances to WAIT_DONE on tx_busy=1.
REQ-021 WAIT_DONE on tx_busy=0 goes to RELEASE if last_q=1, else back to SEND.
REQ-022 RELEASE:
- ptr becomes (g+1) mod NREQ;
- grant_valid=0;
- next state is IDLE, so there is at least one idle cycle between packets.
REQ-023 The grant is locked for the whole packet; other requesters' req_valid is ignored until RELEASE.
REQ-024 ptr wraps from NREQ-1 to 0; a requester set to 0 after one release is valid.
REQ-025 Minimum byte period is 1 (SEND) + 1 (WAIT_BUSY, assuming tx_busy rises the cycle after tx_start) + the frame length.
REQ-026 A single-byte packet (req_last=1 on the first byte) is legal.
REQ-027 tx_start shall never assert while tx_busy=1.
REQ-028 When req_valid and req_last change while not granted, there is no effect.

Reset
REQ-029 On rst_n low, immediately and asynchronously:
- state=IDLE, ptr=0, last_q=0, idle counter=0;
- grant_valid=0, grant_id=0, tx_start=0, tx_data=0x00, req_ready=0, timeout_evt=0.
REQ-030 Reset asserted mid-packet abandons the packet; after release the block re-arbitrates from ptr=0.
REQ-031 rst_n deassertion is synchronised externally; the block adds no synchroniser.

Structure
REQ-032 The shared package uart_pkg holds:
- the state enumeration;
- the BYTE_W=8 constant;
- the CLK_HZ=12_000_000 constant;
- the BAUD=9600 constant.
REQ-033 One sub-module, rr_pick, does the combinational round-robin choice: inputs req and ptr, outputs idx and any.

Verification
REQ-034 Test harness:
- the transmitter is a stub that raises tx_busy one cycle after tx_start and holds it for 10 cycles;
- the clock period is 84 ns;
- every test starts with rst_n low for 5 cycles.
REQ-035 Scenario 1: requester 0 sends "abcd", last on 'd' -> tx_data 0x61, 0x62, 0x63, 0x64 in order, 4 req_ready[0] pulses, grant_valid drops after 'd', ptr=1.
REQ-036 Scenario 2: all four requesters send 1-byte packets 0x10..0x13 simultaneously -> transmission order 0, 1, 2, 3, then ptr=0.
REQ-037 Scenario 3: requester 2 is locked mid-packet while requester 1 is valid -> no requester-1 byte until requester 2's last byte completes.
REQ-038 Scenario 4: requester 3 drops req_valid after 1 byte without last -> timeout_evt after 1200 cycles, then requester 0 (valid) is granted.
REQ-039 Scenario 5: rst_n pulsed low during WAIT_DONE -> all outputs 0 within the same cycle, IDLE, no stray tx_start.
REQ-040 Scenario 6: tx_busy held high 50 cycles -> exactly one tx_start per byte, none while busy.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states and link constants.
`timescale 1ns/1ps
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam int CLK_HZ = 12_000_000;
    localparam int BAUD   = 9600;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE,
        RELEASE
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin choice: first asserted request at or after ptr, wrapping.
`timescale 1ns/1ps
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IDW = $clog2(NREQ);

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return IDW'(sum);
    endfunction

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            if (!any && req[wrap_add(ptr, off)]) begin
                any = 1'b1;
                idx = wrap_add(ptr, off);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Locks one requester onto the shared UART transmitter for a whole packet,
// round-robin between packets, with an idle timeout that revokes a stalled lock.
`timescale 1ns/1ps
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int IDLE_TIMEOUT = 1200
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [BYTE_W*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx_start,
    output logic [BYTE_W-1:0]        tx_data,
    input  logic                     tx_busy,
    output logic                     grant_valid,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     timeout_evt
);

    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = $clog2(IDLE_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic                last_q, last_d;
    logic [CNTW-1:0]     idle_cnt_q, idle_cnt_d;
    logic                grant_valid_q, grant_valid_d;
    logic [IDW-1:0]      grant_id_q, grant_id_d;
    logic                tx_start_q, tx_start_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic [NREQ-1:0]     req_ready_q, req_ready_d;
    logic                timeout_evt_q, timeout_evt_d;

    logic [IDW-1:0]      pick_idx;
    logic                pick_any;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        ptr_d         = ptr_q;
        last_d        = last_q;
        idle_cnt_d    = idle_cnt_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        req_ready_d   = '0;
        timeout_evt_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_valid_d = 1'b1;
                    grant_id_d    = pick_idx;
                    idle_cnt_d    = '0;
                    state_d       = SEND;
                end
            end
            SEND: begin
                // A byte is only launched while the transmitter is free.
                if (req_valid[grant_id_q]) begin
                    if (!tx_busy) begin
                        tx_start_d              = 1'b1;
                        tx_data_d               = req_data[BYTE_W*int'(grant_id_q) +: BYTE_W];
                        req_ready_d[grant_id_q] = 1'b1;
                        last_d                  = req_last[grant_id_q];
                        idle_cnt_d              = '0;
                        state_d                 = WAIT_BUSY;
                    end
                end else if (idle_cnt_q == CNTW'(IDLE_TIMEOUT - 1)) begin
                    timeout_evt_d = 1'b1;
                    state_d       = RELEASE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = last_q ? RELEASE : SEND;
            end
            RELEASE: begin
                ptr_d         = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
                grant_valid_d = 1'b0;
                idle_cnt_d    = '0;
                last_d        = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            last_q        <= 1'b0;
            idle_cnt_q    <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            req_ready_q   <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            last_q        <= last_d;
            idle_cnt_q    <= idle_cnt_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            req_ready_q   <= req_ready_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a busy-stub transmitter and a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int IDLE_TIMEOUT = 1200;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [8*NREQ-1:0]   req_data = '0;
    logic [NREQ-1:0]     req_last = '0;
    logic [NREQ-1:0]     req_ready;
    logic                tx_start;
    logic [7:0]          tx_data;
    logic                tx_busy;
    logic                grant_valid;
    logic [1:0]          grant_id;
    logic                timeout_evt;

    uart_tx_arbiter #(.NREQ(NREQ), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout_evt (timeout_evt)
    );

    always #42 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_start = 0;
    int n_timeout = 0;
    int n_ready [NREQ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter stub: busy rises the cycle after tx_start and holds busy_len cycles.
    int   busy_len = 10;
    int   busy_cnt = 0;
    logic stub_busy = 1'b0;
    logic busy_force = 1'b0;
    always @(posedge clk) begin
        if (tx_start) begin
            stub_busy <= 1'b1;
            busy_cnt  <= busy_len - 1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            stub_busy <= 1'b0;
        end
    end
    assign tx_busy = stub_busy | busy_force;

    // Requester model: per-requester ring of {data,last}, advanced on req_ready.
    typedef struct packed { logic [7:0] data; logic last; } item_t;
    item_t mem [NREQ][32];
    int head [NREQ];
    int tail [NREQ];

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (!rst_n) head[i] = tail[i];
            else if (req_ready[i] && head[i] != tail[i]) head[i] = head[i] + 1;
            req_valid[i]       = (head[i] != tail[i]);
            req_data[8*i +: 8] = mem[i][head[i] % 32].data;
            req_last[i]        = mem[i][head[i] % 32].last;
        end
    end

    // Scoreboard of {grant_id, byte} in expected transmission order.
    logic [9:0] sb [$];

    always @(negedge clk) begin
        logic [9:0] e;
        logic [3:0] onehot;
        if (rst_n) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) n_ready[i]++;
            if (timeout_evt) n_timeout++;
            if (tx_start) begin
                n_start++;
                check("start_while_busy", {31'd0, tx_busy}, 32'd0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_tx_start: got tx_data 0x%0h, expected no byte", tx_data);
                end else begin
                    e = sb.pop_front();
                    onehot = 4'b0001 << e[9:8];
                    check("tx_data", {24'd0, tx_data}, {24'd0, e[7:0]});
                    check("grant_id", {30'd0, grant_id}, {30'd0, e[9:8]});
                    check("req_ready", {28'd0, req_ready}, {28'd0, onehot});
                end
            end else if (req_ready != '0) begin
                check("ready_without_start", {28'd0, req_ready}, 32'd0);
            end
        end
    end

    task automatic load(input int id, input logic [7:0] d, input logic lst);
        mem[id][tail[id] % 32] = '{data: d, last: lst};
        tail[id] = tail[id] + 1;
    endtask

    task automatic expect_byte(input logic [1:0] id, input logic [7:0] d);
        sb.push_back({id, d});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !grant_valid) done = 1'b1;
        end
        check("drain", {31'd0, done}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_grant(input logic [1:0] id, input int budget);
        bit got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (grant_valid && grant_id == id) got = 1'b1;
        end
        check("wait_grant", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_start(input int budget);
        int s0;
        bit got = 1'b0;
        s0 = n_start;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (n_start != s0) got = 1'b1;
        end
        check("wait_start", {31'd0, got}, 32'd1);
    endtask

    typedef struct packed {
        logic            do_rst;
        logic [3:0]      mask;
        logic [2:0]      n;
        logic [3:0][1:0] order;
    } vec_t;
    vec_t vecs [6];

    initial begin
        #(84 * 60000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int cyc;
        bit seen;

        // One-byte packets 0x10+id on every requester in mask; expected grant order listed first-to-last from bit 0.
        vecs[0] = '{do_rst: 1'b1, mask: 4'b0001, n: 3'd1, order: {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[1] = '{do_rst: 1'b0, mask: 4'b0011, n: 3'd2, order: {2'd0, 2'd0, 2'd0, 2'd1}};
        vecs[2] = '{do_rst: 1'b1, mask: 4'b1111, n: 3'd4, order: {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[3] = '{do_rst: 1'b0, mask: 4'b1001, n: 3'd2, order: {2'd0, 2'd0, 2'd3, 2'd0}};
        vecs[4] = '{do_rst: 1'b0, mask: 4'b1100, n: 3'd2, order: {2'd0, 2'd0, 2'd3, 2'd2}};
        vecs[5] = '{do_rst: 1'b1, mask: 4'b1010, n: 3'd2, order: {2'd0, 2'd0, 2'd3, 2'd1}};

        // Reset state.
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_grant_valid", {31'd0, grant_valid}, 32'd0);
        check("rst_grant_id", {30'd0, grant_id}, 32'd0);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_timeout", {31'd0, timeout_evt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // "abcd" from requester 0, then ptr must favour requester 1.
        for (int i = 0; i < 4; i++) begin
            load(0, 8'h61 + 8'(i), i == 3);
            expect_byte(2'd0, 8'h61 + 8'(i));
        end
        drain(300);
        check("abcd_ready_pulses", n_ready[0], 32'd4);
        check("abcd_grant_dropped", {31'd0, grant_valid}, 32'd0);
        load(0, 8'h70, 1'b1);
        load(1, 8'h71, 1'b1);
        expect_byte(2'd1, 8'h71);
        expect_byte(2'd0, 8'h70);
        drain(300);

        // Round-robin table.
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].do_rst) do_reset();
            for (int i = 0; i < NREQ; i++)
                if (vecs[v].mask[i]) load(i, 8'h10 + 8'(i), 1'b1);
            for (int k = 0; k < int'(vecs[v].n); k++)
                expect_byte(vecs[v].order[k], 8'h10 + 8'(vecs[v].order[k]));
            drain(400);
        end

        // Requester 2 locked mid-packet while requester 1 becomes valid.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            load(2, 8'h20 + 8'(i), i == 2);
            expect_byte(2'd2, 8'h20 + 8'(i));
        end
        wait_grant(2'd2, 20);
        load(1, 8'h30, 1'b0);
        load(1, 8'h31, 1'b1);
        expect_byte(2'd1, 8'h30);
        expect_byte(2'd1, 8'h31);
        drain(400);

        // Requester 3 stalls without last; timeout, then requester 0 served.
        do_reset();
        s0 = n_timeout;
        load(3, 8'h40, 1'b0);
        expect_byte(2'd3, 8'h40);
        wait_grant(2'd3, 20);
        wait_start(20);
        load(0, 8'h50, 1'b1);
        expect_byte(2'd0, 8'h50);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (timeout_evt) seen = 1'b1;
        end
        check("timeout_seen", {31'd0, seen}, 32'd1);
        check("timeout_window", {31'd0, (cyc >= 1195 && cyc <= 1230)}, 32'd1);
        @(negedge clk);
        check("timeout_one_cycle", {31'd0, timeout_evt}, 32'd0);
        wait_grant(2'd0, 20);
        drain(200);
        check("timeout_count", n_timeout - s0, 32'd1);

        // Reset during WAIT_DONE abandons the packet.
        do_reset();
        load(0, 8'h60, 1'b0);
        load(0, 8'h61, 1'b1);
        expect_byte(2'd0, 8'h60);
        wait_start(20);
        repeat (4) @(negedge clk);
        #10 rst_n = 1'b0;
        #1;
        check("midrst_grant_valid", {31'd0, grant_valid}, 32'd0);
        check("midrst_grant_id", {30'd0, grant_id}, 32'd0);
        check("midrst_tx_start", {31'd0, tx_start}, 32'd0);
        check("midrst_tx_data", {24'd0, tx_data}, 32'd0);
        check("midrst_req_ready", {28'd0, req_ready}, 32'd0);
        check("midrst_timeout", {31'd0, timeout_evt}, 32'd0);
        repeat (5) @(posedge clk);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        s0 = n_start;
        repeat (20) @(negedge clk);
        check("midrst_no_stray_start", n_start - s0, 32'd0);
        load(1, 8'h71, 1'b1);
        load(0, 8'h70, 1'b1);
        expect_byte(2'd0, 8'h70);
        expect_byte(2'd1, 8'h71);
        drain(300);

        // Long busy frames: exactly one tx_start per byte.
        do_reset();
        busy_len = 50;
        s0 = n_start;
        for (int i = 0; i < 3; i++) begin
            load(2, 8'h80 + 8'(i), i == 2);
            expect_byte(2'd2, 8'h80 + 8'(i));
        end
        drain(400);
        check("long_busy_starts", n_start - s0, 32'd3);
        busy_len = 10;

        // Transmitter already busy when a grant is made: launch waits for it to free.
        do_reset();
        busy_force = 1'b1;
        s0 = n_start;
        load(1, 8'h90, 1'b1);
        expect_byte(2'd1, 8'h90);
        repeat (20) @(negedge clk);
        check("busy_gate_no_start", n_start - s0, 32'd0);
        check("busy_gate_granted", {31'd0, grant_valid}, 32'd1);
        busy_force = 1'b0;
        drain(100);
        check("busy_gate_one_start", n_start - s0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
